fp_sub_arbiter: RTL and testbench
=================================

Name: fp_sub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one Fp modular subtraction unit (448-bit, MODULUS from parameters_pkg) among NUM_REQ requesters.
- Accepts operand pairs over a valid/ready handshake and issues one start pulse per job.
- Tracks the unit's level-type done flag, returns the result to the owning requester, and flags a hung unit with a watchdog.
- Sits between the point-arithmetic sequencers and the shared subtractor instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 448 (from parameters_pkg), operand/result width.
- TIMEOUT_CYCLES, 16, maximum cycles in WAIT_DONE before the watchdog fires.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request; held with operands until req_ready.
- req_ready  out  NUM_REQ  one-hot one-cycle accept pulse.
- req_a  in  NUM_REQ*DATA_WIDTH  minuends, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  subtrahends, same packing.
- resp_valid  out  NUM_REQ  one-hot one-cycle result strobe.
- resp_data  out  DATA_WIDTH  result, valid with resp_valid; holds last value otherwise.
- sub_start  out  1  start pulse to the subtractor.
- sub_a, sub_b  out  DATA_WIDTH  registered operands, stable from ISSUE through WAIT_DONE.
- sub_result  in  DATA_WIDTH  subtractor result.
- sub_done  in  1  subtractor done (level; clears on the cycle after start, sets when the result is valid).
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag; cleared only by rst.

Behaviour:
- Reset values:
  - State IDLE, rr_ptr=0, owner=0, wd counter=0.
  - req_ready=0, resp_valid=0, resp_data=0, sub_start=0, sub_a=0, sub_b=0, busy=0, timeout_err=0.
- States are IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESPOND.
- IDLE:
  - If any req_valid, grant the first set bit searching from rr_ptr upward, with wrap.
  - Same cycle: req_ready[g]=1, latch sub_a/sub_b from slot g, owner=g, rr_ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - No request: stay; rr_ptr unchanged.
- ISSUE: sub_start=1 for exactly this cycle -> WAIT_CLR.
- WAIT_CLR: sub_done ignored (stale done from the previous job is still visible) -> WAIT_DONE; wd=0.
- WAIT_DONE:
  - sub_done=1: resp_data<=sub_result -> RESPOND.
  - Otherwise wd++.
  - When wd reaches TIMEOUT_CYCLES-1 without done: timeout_err<=1, drop the job (no resp_valid), -> IDLE.
- RESPOND: resp_valid[owner]=1 for one cycle -> IDLE.
- Throughput: one job per 5 + unit-latency cycles. Arbitration happens only in IDLE.
- Requests arriving while busy stay pending; requesters must hold req_valid and operands until req_ready.
- Dropping req_valid before the grant is legal; the request is simply never served.
- No arithmetic in this block: operands and result are forwarded unchanged. Reduction is the unit's job.
- rst in any state (including mid-WAIT_DONE) returns everything to the reset values the next cycle.
  - An in-flight job is lost with no response.
  - The unit may still be running; the next ISSUE restarts it cleanly.
- A requester whose request is granted in IDLE may reassert req_valid with new operands in the very next cycle; it is arbitrated after the current job completes.
- Only one resp_valid and at most one req_ready are ever high in a cycle.

Test Plan:
- Single request, slot 0, a=5, b=3, behavioural subtractor model -> req_ready[0] pulses once, exactly one sub_start, resp_valid[0] with resp_data=2.
- Slot 2, a=3, b=5 -> resp_data=MODULUS-2 = 2^448-2^224-3; resp_valid[2] only.
- All four req_valid high continuously, distinct operands -> grant order 0,1,2,3,0; one job in flight; each response matches its owner's operands.
- Stale sub_done held high from the previous job at ISSUE -> no early response; result is captured only after the WAIT_CLR cycle and reflects the new operands.
- Stub holds sub_done=0 -> timeout_err rises TIMEOUT_CYCLES cycles into WAIT_DONE, no resp_valid, next request is still served, timeout_err stays 1 until rst.
- rst asserted in WAIT_DONE with requests pending -> all outputs 0 next cycle; after rst drops, the pending request at slot 0 (rr_ptr=0) is granted first.

Source files
------------

// File: rtl/fp_sub_arbiter.sv
// Round-robin arbiter/sequencer sharing one Fp modular subtraction unit among NUM_REQ requesters.
// Operands and results pass through untouched; a watchdog catches a unit that never raises done.
package parameters_pkg;
  localparam int DATA_WIDTH = 448;
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};
endpackage

module fp_sub_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = parameters_pkg::DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          sub_start,
  output logic [DATA_WIDTH-1:0]         sub_a,
  output logic [DATA_WIDTH-1:0]         sub_b,
  input  logic [DATA_WIDTH-1:0]         sub_result,
  input  logic                          sub_done,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_CLR  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESPOND   = 3'd4;

  logic [2:0]            state_r;
  logic [2:0]            state_next_s;
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [PTR_W-1:0]      owner_r;
  logic [WD_W-1:0]       wd_r;
  logic [NUM_REQ-1:0]    req_ready_r;
  logic [NUM_REQ-1:0]    resp_valid_r;
  logic [DATA_WIDTH-1:0] resp_data_r;
  logic                  sub_start_r;
  logic [DATA_WIDTH-1:0] sub_a_r;
  logic [DATA_WIDTH-1:0] sub_b_r;
  logic                  busy_r;
  logic                  timeout_err_r;

  logic                  grant_found_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [PTR_W-1:0]      cand_s;
  logic [PTR_W-1:0]      rr_ptr_next_s;
  logic                  wd_expired_s;

  assign wd_expired_s  = (wd_r == WD_W'(TIMEOUT_CYCLES - 1));
  assign rr_ptr_next_s = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);

  // Round-robin search: first valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s        = PTR_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      grant_idx_s   = (req_valid[cand_s] && !grant_found_s) ? cand_s : grant_idx_s;
      grant_found_s = grant_found_s | req_valid[cand_s];
    end
  end

  // Next-state decode for the job sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) begin
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE:    state_next_s = ST_WAIT_CLR;
      ST_WAIT_CLR: state_next_s = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (sub_done) begin
          state_next_s = ST_RESPOND;
        end else if (wd_expired_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_WAIT_DONE;
        end
      end
      ST_RESPOND:  state_next_s = ST_IDLE;
      default:     state_next_s = ST_IDLE;
    endcase
  end

  // Sequencer state, arbitration pointer, watchdog and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= '0;
      owner_r       <= '0;
      wd_r          <= '0;
      req_ready_r   <= '0;
      resp_valid_r  <= '0;
      resp_data_r   <= '0;
      sub_start_r   <= 1'b0;
      sub_a_r       <= '0;
      sub_b_r       <= '0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      req_ready_r  <= '0;
      resp_valid_r <= '0;
      sub_start_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            req_ready_r <= NUM_REQ'(1) << grant_idx_s;
            sub_a_r     <= req_a[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            sub_b_r     <= req_b[int'(grant_idx_s)*DATA_WIDTH +: DATA_WIDTH];
            owner_r     <= grant_idx_s;
            rr_ptr_r    <= rr_ptr_next_s;
            sub_start_r <= 1'b1;
          end
        end
        // Done is still showing the previous job here, so it is not looked at.
        ST_WAIT_CLR: wd_r <= '0;
        ST_WAIT_DONE: begin
          if (sub_done) begin
            resp_data_r  <= sub_result;
            resp_valid_r <= NUM_REQ'(1) << owner_r;
          end else if (wd_expired_s) begin
            timeout_err_r <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready   = req_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_data   = resp_data_r;
  assign sub_start   = sub_start_r;
  assign sub_a       = sub_a_r;
  assign sub_b       = sub_b_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Directed bench for fp_sub_arbiter with a behavioural Fp subtractor whose done flag
// lingers one cycle after start and can be forced to hang.
module tb_fp_sub_arbiter;
  localparam int N  = 4;
  localparam int W  = 448;
  localparam int TO = 16;
  localparam logic [W-1:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_data;
  logic           sub_start;
  logic [W-1:0]   sub_a;
  logic [W-1:0]   sub_b;
  logic [W-1:0]   sub_result;
  logic           sub_done;
  logic           busy;
  logic           timeout_err;

  int checks = 0;
  int errors = 0;

  fp_sub_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_data(resp_data),
    .sub_start(sub_start), .sub_a(sub_a), .sub_b(sub_b), .sub_result(sub_result),
    .sub_done(sub_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fsub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, P} - {1'b0, b};
    return t[W-1:0];
  endfunction

  // Behavioural unit: done clears one cycle after start is seen, sets after lat cycles.
  int           lat  = 3;
  logic         hang = 1'b0;
  int           cnt;
  logic [W-1:0] opa, opb;
  always @(posedge clk) begin
    if (rst) begin
      cnt        <= 0;
      sub_done   <= 1'b0;
      sub_result <= '0;
    end else if (sub_start) begin
      cnt <= lat;
      opa <= sub_a;
      opb <= sub_b;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == lat) sub_done <= 1'b0;
      if (cnt == 1) begin
        sub_done   <= !hang;
        sub_result <= fsub(opa, opb);
      end
    end
  end

  int start_cnt = 0;
  int resp_cnt  = 0;
  int multi_cnt = 0;
  always begin
    @(negedge clk);
    #1;
    if (sub_start === 1'b1) start_cnt++;
    if (resp_valid != '0) resp_cnt++;
    if ($countones(req_ready) > 1 || $countones(resp_valid) > 1) multi_cnt++;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int s, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[s*W +: W] = a;
    req_b[s*W +: W] = b;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready == '0 && cyc < 40);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (resp_valid == '0 && cyc < 60);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"},   W'(req_ready),   W'(4'b0000));
    chk({tag, "_resp_valid"},  W'(resp_valid),  W'(4'b0000));
    chk({tag, "_resp_data"},   resp_data,       W'(1'b0));
    chk({tag, "_sub_start"},   W'(sub_start),   W'(1'b0));
    chk({tag, "_sub_a"},       sub_a,           W'(1'b0));
    chk({tag, "_sub_b"},       sub_b,           W'(1'b0));
    chk({tag, "_busy"},        W'(busy),        W'(1'b0));
    chk({tag, "_timeout_err"}, W'(timeout_err), W'(1'b0));
  endtask

  initial begin
    int cyc;
    int s0, r0;
    logic seen;
    logic [W-1:0] rr_exp [N];

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;

    // Single request on slot 0: 5 - 3.
    #2; s0 = start_cnt;
    set_slot(0, W'(5), W'(3));
    req_valid = 4'b0001;
    wait_ready(cyc);
    chk("t1_ready", W'(req_ready), W'(4'b0001));
    chk("t1_sub_a", sub_a, W'(5));
    chk("t1_sub_b", sub_b, W'(3));
    chk("t1_start", W'(sub_start), W'(1'b1));
    chk("t1_busy", W'(busy), W'(1'b1));
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk("t1_latency", W'(cyc), W'(5));
    chk("t1_resp_valid", W'(resp_valid), W'(4'b0001));
    chk("t1_resp_data", resp_data, W'(2));
    @(negedge clk);
    chk("t1_resp_pulse", W'(resp_valid), W'(4'b0000));
    chk("t1_resp_hold", resp_data, W'(2));
    chk("t1_idle", W'(busy), W'(1'b0));
    #2;
    chk("t1_one_start", W'(start_cnt - s0), W'(1));

    // Slot 2: 3 - 5 wraps to MODULUS - 2.
    set_slot(2, W'(3), W'(5));
    req_valid = 4'b0100;
    wait_ready(cyc);
    chk("t2_ready", W'(req_ready), W'(4'b0100));
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk("t2_resp_valid", W'(resp_valid), W'(4'b0100));
    chk("t2_resp_data", resp_data, P - W'(2));

    // Restart pointer at 0 and keep all four requesting.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_slot(0, W'(10), W'(1));
    set_slot(1, W'(20), W'(25));
    set_slot(2, W'(30), W'(7));
    set_slot(3, W'(40), W'(40));
    rr_exp[0] = W'(9);
    rr_exp[1] = P - W'(5);
    rr_exp[2] = W'(23);
    rr_exp[3] = W'(0);
    #2; s0 = start_cnt; r0 = resp_cnt;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ready(cyc);
      chk($sformatf("rr%0d_ready", j), W'(req_ready), W'(4'(1) << (j % N)));
      wait_resp(cyc);
      chk($sformatf("rr%0d_resp_valid", j), W'(resp_valid), W'(4'(1) << (j % N)));
      chk($sformatf("rr%0d_resp_data", j), resp_data, rr_exp[j % N]);
    end
    req_valid = 4'b0000;
    #2;
    chk("rr_starts", W'(start_cnt - s0), W'(5));
    chk("rr_resps", W'(resp_cnt - r0), W'(5));

    // Done still high from the last job; new job on slot 3 must wait for its own result.
    lat = 2;
    set_slot(3, W'(1000), W'(1));
    req_valid = 4'b1000;
    @(negedge clk);
    chk("stale_done_pre", W'(sub_done), W'(1'b1));
    wait_ready(cyc);
    chk("stale_ready", W'(req_ready), W'(4'b1000));
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk("stale_latency", W'(cyc), W'(4));
    chk("stale_resp_valid", W'(resp_valid), W'(4'b1000));
    chk("stale_resp_data", resp_data, W'(999));

    // Hung unit on slot 1: watchdog fires 16 cycles into WAIT_DONE, job dropped.
    @(negedge clk);
    lat  = 3;
    hang = 1'b1;
    set_slot(1, W'(77), W'(7));
    req_valid = 4'b0010;
    wait_ready(cyc);
    chk("to_ready", W'(req_ready), W'(4'b0010));
    req_valid = 4'b0000;
    seen = 1'b0;
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1'b1;
    end
    chk("to_not_yet", W'(timeout_err), W'(1'b0));
    @(negedge clk);
    if (resp_valid != '0) seen = 1'b1;
    chk("to_flag", W'(timeout_err), W'(1'b1));
    chk("to_idle", W'(busy), W'(1'b0));
    chk("to_no_resp", W'(seen), W'(1'b0));

    // Unit recovers; flag stays sticky.
    hang = 1'b0;
    set_slot(2, W'(50), W'(8));
    req_valid = 4'b0100;
    wait_ready(cyc);
    chk("rec_ready", W'(req_ready), W'(4'b0100));
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk("rec_resp_valid", W'(resp_valid), W'(4'b0100));
    chk("rec_resp_data", resp_data, W'(42));
    chk("rec_sticky", W'(timeout_err), W'(1'b1));

    // Reset in WAIT_DONE with slots 0 and 1 pending; slot 0 goes first afterwards.
    @(negedge clk);
    lat = 10;
    set_slot(0, W'(9), W'(4));
    req_valid = 4'b0001;
    wait_ready(cyc);
    chk("rst_ready", W'(req_ready), W'(4'b0001));
    set_slot(0, W'(70), W'(7));
    set_slot(1, W'(60), W'(1));
    req_valid = 4'b0011;
    #2; r0 = resp_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("midrst");
    rst = 1'b0;
    lat = 3;
    wait_ready(cyc);
    chk("post_rst_ready", W'(req_ready), W'(4'b0001));
    chk("post_rst_sub_a", sub_a, W'(70));
    req_valid = 4'b0010;
    wait_resp(cyc);
    chk("post_rst_resp_valid", W'(resp_valid), W'(4'b0001));
    chk("post_rst_resp_data", resp_data, W'(63));
    #2;
    chk("lost_job_no_resp", W'(resp_cnt - r0), W'(1));
    wait_ready(cyc);
    chk("slot1_ready", W'(req_ready), W'(4'b0010));
    req_valid = 4'b0000;
    wait_resp(cyc);
    chk("slot1_resp_valid", W'(resp_valid), W'(4'b0010));
    chk("slot1_resp_data", resp_data, W'(59));

    @(negedge clk);
    #2;
    chk("onehot_strobes", W'(multi_cnt), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
